// File: rtl/serial_word_comparator_pkg.sv
// serial_word_comparator_pkg: constants shared by the serial comparator and its flag consumers
package serial_word_comparator_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic {ST_IDLE = 1'b0, ST_CMP = 1'b1} state_e;
  // Flag vector layout is {less, equal, greater}
  localparam int FLAG_GREATER = 0;
  localparam int FLAG_EQUAL = 1;
  localparam int FLAG_LESS = 2;
  localparam logic [2:0] FLAGS_NONE = 3'b000;
  localparam logic [2:0] FLAGS_GREATER = 3'b001 << FLAG_GREATER;
  localparam logic [2:0] FLAGS_EQUAL = 3'b001 << FLAG_EQUAL;
  localparam logic [2:0] FLAGS_LESS = 3'b001 << FLAG_LESS;
endpackage

// File: rtl/serial_word_comparator_nibble_cmp.sv
// nibble_cmp: combinational 4-bit unsigned compare
//   a_i, b_i : nibbles to compare
//   lt_o, eq_o, gt_o : a_i<b_i, a_i==b_i, a_i>b_i
module nibble_cmp
  import serial_word_comparator_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  output logic                lt_o,
  output logic                eq_o,
  output logic                gt_o
);
  assign lt_o = a_i < b_i;
  assign eq_o = a_i == b_i;
  assign gt_o = a_i > b_i;
endmodule

// File: rtl/serial_word_comparator.sv
// serial_word_comparator: MSB-first nibble-serial unsigned magnitude compare with early exit
//   clk, rst           : clock, async active-high reset
//   start, a, b        : request and operands, sampled only when idle
//   busy, done         : compare in progress, one-cycle result strobe
//   less, greater, equal : result flags, held from done until the next accepted start
module serial_word_comparator
  import serial_word_comparator_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                      busy,
  output logic                      done,
  output logic                      less,
  output logic                      greater,
  output logic                      equal
);
  localparam int W = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0] flags_q, flags_d;
  logic done_q, done_d;
  logic lt, eq, gt;
  nibble_cmp u_nibble_cmp (
    .a_i (a_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .b_i (b_q[idx_q*NIBBLE_W +: NIBBLE_W]),
    .lt_o(lt),
    .eq_o(eq),
    .gt_o(gt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      flags_q <= FLAGS_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        a_d     = a;
        b_d     = b;
        idx_d   = IW'(NIBBLES - 1);
        flags_d = FLAGS_NONE;
        state_d = ST_CMP;
      end
    end else if (!eq || idx_q == '0) begin
      // First differing nibble decides; reaching nibble 0 still equal means the words match
      flags_d = gt ? FLAGS_GREATER : lt ? FLAGS_LESS : FLAGS_EQUAL;
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end else begin
      idx_d = idx_q - IW'(1);
    end
  end
  always_comb begin
    busy    = state_q == ST_CMP;
    done    = done_q;
    less    = flags_q[FLAG_LESS];
    greater = flags_q[FLAG_GREATER];
    equal   = flags_q[FLAG_EQUAL];
  end
endmodule

// File: tb/tb_serial_word_comparator.sv
// tb_serial_word_comparator: directed and random checks of serial_word_comparator against a word-level model
module tb_serial_word_comparator;
  localparam int N = 4;
  localparam int W = 4 * N;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, less, greater, equal;
  int n_checks = 0;
  int n_pass = 0;
  serial_word_comparator #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .less(less), .greater(greater), .equal(equal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Nibbles examined MSB-first until the first difference, all of them if equal
  function automatic int exp_cycles(input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int i = N - 1; i >= 0; i--)
      if (((av >> (4 * i)) & 16'hF) != ((bv >> (4 * i)) & 16'hF)) return N - i;
    return N;
  endfunction
  // Runs one compare; disturb changes operands while busy, mid_start pulses start in the 2nd busy cycle,
  // chain leaves the bench in the done cycle so the next call's start is accepted back-to-back
  task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input bit disturb,
                        input bit mid_start, input bit chain);
    int m;
    logic [2:0] exp_f;
    m = exp_cycles(av, bv);
    exp_f = {av < bv, av == bv, av > bv};
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_flags", {less, equal, greater}, 0);
    for (int c = 1; c <= m; c++) begin
      if (disturb) begin
        a = 16'hFFFF;
        b = 16'h0000;
      end
      tick();
      if (c < m) begin
        chk("busy_mid", {busy, done}, 2'b10);
        if (mid_start && c == 1) begin
          a = 16'h9999;
          b = 16'h0000;
          start = 1'b1;
        end else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_pulse", {busy, done}, 2'b01);
    chk("flags", {less, equal, greater}, exp_f);
    if (!chain) begin
      tick();
      chk("done_once", {busy, done}, 2'b00);
      chk("flags_hold", {less, equal, greater}, exp_f);
    end
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    #3;
    chk("reset_out", {busy, done, less, equal, greater}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_out", {busy, done, less, equal, greater}, 0);
    do_cmp(16'h1234, 16'h1234, 0, 0, 0);
    do_cmp(16'h8000, 16'h7FFF, 0, 0, 0);
    tick();
    chk("flags_hold_idle", {less, equal, greater}, 3'b001);
    do_cmp(16'h12A4, 16'h12B0, 1, 0, 0);
    do_cmp(16'h0001, 16'h0002, 0, 1, 0);
    a = 16'h5555;
    b = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1 chk("async_rst", {busy, done, less, equal, greater}, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) rst = 1'b0;
      chk("no_done_after_rst", {busy, done, less, equal, greater}, 0);
    end
    do_cmp(16'h0010, 16'h0001, 0, 0, 0);
    do_cmp(16'hF000, 16'hE000, 0, 0, 1);
    do_cmp(16'h0000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ra;
      if ($urandom_range(0, 4) != 0) rb[4 * $urandom_range(0, N - 1) +: 4] = 4'($urandom);
      do_cmp(ra, rb, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 2) == 0);
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
